// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the requesters / uart_tx side and uart_tx_arbiter.
// Requesters and the transmitter sit on the master side; the arbiter is the slave.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]   i_last;
  logic [N_REQ-1:0]   o_ack;
  logic [N_REQ-1:0]   o_grant;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               i_tx_busy;
  logic               o_active;
  logic               o_timeout;

  modport master (
    output i_req, i_data, i_last, i_tx_busy,
    input  o_ack, o_grant, o_tx_data, o_tx_start, o_active, o_timeout
  );

  modport slave (
    input  i_req, i_data, i_last, i_tx_busy,
    output o_ack, o_grant, o_tx_data, o_tx_start, o_active, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among N_REQ byte streams,
// sequencing the tx_start/tx_busy handshake and flagging a transmitter that never starts.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned START_TIMEOUT = 8
) (
  input logic              i_Clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [PW-1:0]    owner, owner_n, owner_inc;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic [N_REQ-1:0] ack_q, ack_n;
  logic [7:0]       tx_data_q, tx_data_n;
  logic             tx_start_q, tx_start_n;
  logic             active_q, active_n;
  logic             timeout_q, timeout_n;
  logic             last_q, last_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             byte_done;

  logic             pick_found;
  logic [PW-1:0]    pick, idx;
  logic [7:0]       sel_data;
  logic             sel_last, sel_req;

  assign owner_inc = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Search upward from ptr with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!pick_found && bus.i_req[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
      idx = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_req  = 1'b0;
    for (int unsigned r = 0; r < N_REQ; r++) begin
      if (owner == PW'(r)) begin
        sel_data = bus.i_data[8*r +: 8];
        sel_last = bus.i_last[r];
        sel_req  = bus.i_req[r];
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    grant_n    = grant_q;
    ack_n      = '0;
    tx_data_n  = tx_data_q;
    tx_start_n = 1'b0;
    timeout_n  = timeout_q;
    last_n     = last_q;
    cnt_n      = cnt;
    byte_done  = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          owner_n = pick;
          grant_n = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (sel_req) begin
          tx_data_n = sel_data;
          last_n    = sel_last;
          ack_n     = grant_q;
          state_n   = START;
        end else begin
          grant_n = '0;
          ptr_n   = owner_inc;
          state_n = IDLE;
        end
      end
      START: begin
        if (!bus.i_tx_busy) begin
          tx_start_n = 1'b1;
          cnt_n      = '0;
          state_n    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.i_tx_busy) begin
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(START_TIMEOUT)) begin
            timeout_n = 1'b1;
            byte_done = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.i_tx_busy) byte_done = 1'b1;
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase

    // A timed-out byte takes the same exit as a normally completed one.
    if (byte_done) begin
      if (last_q) begin
        grant_n = '0;
        ptr_n   = owner_inc;
        state_n = IDLE;
      end else begin
        state_n = LOAD;
      end
    end

    active_n = (state_n != IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      owner      <= owner_n;
      grant_q    <= grant_n;
      ack_q      <= ack_n;
      tx_data_q  <= tx_data_n;
      tx_start_q <= tx_start_n;
      active_q   <= active_n;
      timeout_q  <= timeout_n;
      last_q     <= last_n;
      cnt        <= cnt_n;
    end
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_ack      = ack_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_active   = active_q;
  assign bus.o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin model plus per-cycle checker,
// with directed scenarios for single packet, contention, fairness, abort, timeout, reset.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (.i_Clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // requester byte streams
  logic [7:0] rq_data [N][16];
  logic       rq_last [N][16];
  int         rq_head [N];
  int         rq_tail [N];

  // transaction-level expectations
  logic [7:0] exp_byte[$];
  int         exp_byte_own[$];
  int         exp_own[$];
  int         exp_ptr[$];
  int         got_own[$];
  int         hist[$];
  int         mptr = 0;
  int         start_cnt [N];

  // uart_tx and timeout model
  bit dead     = 1'b0;
  int busy_len = 20;
  int busy_cnt = 0;
  int cyc      = 0;
  int to_at    = -1;
  bit exp_to   = 1'b0;
  bit fair_on  = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic void load(int r, logic [7:0] d, logic l);
    rq_data[r][rq_tail[r]] = d;
    rq_last[r][rq_tail[r]] = l;
    rq_tail[r]++;
  endfunction

  function automatic void clear_all();
    for (int r = 0; r < N; r++) begin
      rq_head[r]   = 0;
      rq_tail[r]   = 0;
      start_cnt[r] = 0;
    end
    exp_byte.delete();
    exp_byte_own.delete();
    exp_own.delete();
    exp_ptr.delete();
    got_own.delete();
  endfunction

  // Packets are served whole, owner chosen upward from the pointer, pointer moves past owner.
  function automatic void predict();
    int  h [N];
    int  r, c;
    bit  found, lst;
    for (int i = 0; i < N; i++) h[i] = rq_head[i];
    r = 0;
    do begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (!found && h[c] < rq_tail[c]) begin
          found = 1'b1;
          r = c;
        end
      end
      if (found) begin
        exp_own.push_back(r);
        lst = 1'b0;
        while (!lst && h[r] < rq_tail[r]) begin
          exp_byte.push_back(rq_data[r][h[r]]);
          exp_byte_own.push_back(r);
          lst = rq_last[r][h[r]];
          h[r]++;
        end
        mptr = (r + 1) % N;
        exp_ptr.push_back(mptr);
      end
    end while (found);
  endfunction

  function automatic int gidx(logic [N-1:0] g);
    int k;
    k = -1;
    for (int r = 0; r < N; r++) if (g[r]) k = r;
    return k;
  endfunction

  // Per-cycle checker, requester model and uart_tx model.
  initial begin
    logic [N-1:0]   prev_grant;
    logic [N-1:0]   req_v, last_v;
    logic [8*N-1:0] data_v;
    int             o, g;
    logic [7:0]     b;
    prev_grant    = '0;
    bus.i_req     = '0;
    bus.i_data    = '0;
    bus.i_last    = '0;
    bus.i_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_grant", 32'(bus.o_grant), 0);
        chk("rst_ack", 32'(bus.o_ack), 0);
        chk("rst_tx_start", 32'(bus.o_tx_start), 0);
        chk("rst_active", 32'(bus.o_active), 0);
        chk("rst_timeout", 32'(bus.o_timeout), 0);
        chk("rst_tx_data", 32'(bus.o_tx_data), 0);
        busy_cnt      = 0;
        bus.i_tx_busy = 1'b0;
        exp_to        = 1'b0;
        to_at         = -1;
        prev_grant    = '0;
      end else begin
        if (cyc == to_at) exp_to = 1'b1;
        chk("timeout", 32'(bus.o_timeout), 32'(exp_to));
        chk("active", 32'(bus.o_active), 32'(|bus.o_grant));
        chk("grant_onehot", 32'($onehot0(bus.o_grant)), 1);
        chk("ack_owner", 32'(bus.o_ack & ~bus.o_grant), 0);
        g = gidx(bus.o_grant);

        if (prev_grant == '0 && bus.o_grant != '0) begin
          got_own.push_back(g);
          if (exp_own.size() == 0) chk("grant_unexpected", 32'(bus.o_grant), 0);
          else begin
            o = exp_own.pop_front();
            chk("grant_order", 32'(bus.o_grant), 32'(1) << o);
          end
          if (fair_on) begin
            foreach (hist[k]) chk("fair_window", 32'(hist[k] == g), 0);
            hist.push_back(g);
            if (hist.size() > 3) void'(hist.pop_front());
          end
        end
        if (prev_grant != '0 && bus.o_grant == '0) begin
          if (exp_ptr.size() == 0) chk("release_unexpected", 32'(prev_grant), 0);
          else chk("ptr_after_pkt", 32'(dut.ptr), 32'(exp_ptr.pop_front()));
        end
        prev_grant = bus.o_grant;

        if (bus.o_tx_start) begin
          if (g >= 0) start_cnt[g]++;
          if (exp_byte.size() == 0) chk("start_unexpected", 32'(bus.o_tx_start), 0);
          else begin
            b = exp_byte.pop_front();
            o = exp_byte_own.pop_front();
            chk("tx_data", 32'(bus.o_tx_data), 32'(b));
            chk("tx_owner", 32'(bus.o_grant), 32'(1) << o);
          end
        end

        for (int r = 0; r < N; r++) begin
          if (bus.o_ack[r]) begin
            if (rq_head[r] < rq_tail[r]) rq_head[r]++;
            else chk("ack_empty", 32'(bus.o_ack[r]), 0);
          end
        end

        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) bus.i_tx_busy = 1'b0;
        end
        if (bus.o_tx_start) begin
          if (dead) to_at = cyc + TO;
          else begin
            busy_cnt      = busy_len;
            bus.i_tx_busy = 1'b1;
          end
        end
      end

      req_v  = '0;
      last_v = '0;
      data_v = '0;
      for (int r = 0; r < N; r++) begin
        if (rq_head[r] < rq_tail[r]) begin
          req_v[r]          = 1'b1;
          last_v[r]         = rq_last[r][rq_head[r]];
          data_v[8*r +: 8]  = rq_data[r][rq_head[r]];
        end
      end
      bus.i_req  = req_v;
      bus.i_last = last_v;
      bus.i_data = data_v;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    mptr = 0;
    clear_all();
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_byte.size() == 0 && exp_own.size() == 0 && exp_ptr.size() == 0 &&
             bus.o_grant == '0 && !bus.i_tx_busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    clear_all();
    // reset state
    tick();
    tick();
    chk("rst_ptr", 32'(dut.ptr), 0);
    chk("rst_data_lit", 32'(bus.o_tx_data), 32'h00);

    // single packet "Hi\r\n" from requester 2, 10 bit-times of 217 clocks
    busy_len = 2170;
    load(2, 8'h48, 1'b0);
    load(2, 8'h69, 1'b0);
    load(2, 8'h0D, 1'b0);
    load(2, 8'h0A, 1'b1);
    predict();
    tick();
    rst = 1'b0;
    tick();
    chk("t1_grant", 32'(bus.o_grant), 32'b0100);
    chk("t1_ack_early", 32'(bus.o_ack), 0);
    tick();
    chk("t1_ack", 32'(bus.o_ack), 32'b0100);
    chk("t1_data", 32'(bus.o_tx_data), 32'h48);
    tick();
    chk("t1_start", 32'(bus.o_tx_start), 1);
    chk("t1_start_grant", 32'(bus.o_grant), 32'b0100);
    wait_idle("t1_done", 12000);
    chk("t1_starts", 32'(start_cnt[2]), 4);
    chk("t1_ptr", 32'(dut.ptr), 3);

    // contention from reset: requesters 0 and 3
    do_reset();
    busy_len = 20;
    load(0, 8'h10, 1'b0);
    load(0, 8'h11, 1'b0);
    load(0, 8'h12, 1'b1);
    load(3, 8'h30, 1'b0);
    load(3, 8'h31, 1'b1);
    predict();
    tick();
    rst = 1'b0;
    wait_idle("t2_done", 1000);
    chk("t2_starts0", 32'(start_cnt[0]), 3);
    chk("t2_starts3", 32'(start_cnt[3]), 2);
    chk("t2_first", 32'(got_own.size() > 0 ? got_own[0] : -1), 0);
    chk("t2_second", 32'(got_own.size() > 1 ? got_own[1] : -1), 3);
    chk("t2_ptr", 32'(dut.ptr), 0);

    // fairness: every requester holds two 1-byte packets
    clear_all();
    for (int r = 0; r < N; r++) begin
      load(r, 8'(8'h80 + r), 1'b1);
      load(r, 8'(8'h90 + r), 1'b1);
    end
    predict();
    hist.delete();
    fair_on = 1'b1;
    tick();
    wait_idle("t3_done", 2000);
    fair_on = 1'b0;
    chk("t3_ngrants", 32'(got_own.size()), 8);
    for (int i = 0; i < 8; i++)
      chk("t3_order", 32'(got_own.size() > i ? got_own[i] : -1), 32'(i % 4));

    // abort: requester 1 drops req after its second byte, requester 2 waiting
    clear_all();
    load(1, 8'h51, 1'b0);
    load(1, 8'h52, 1'b0);
    load(2, 8'h61, 1'b1);
    predict();
    tick();
    wait_idle("t4_done", 1000);
    chk("t4_starts1", 32'(start_cnt[1]), 2);
    chk("t4_starts2", 32'(start_cnt[2]), 1);
    chk("t4_next_owner", 32'(got_own.size() > 1 ? got_own[1] : -1), 2);
    chk("t4_ptr", 32'(dut.ptr), 3);

    // timeout: transmitter never raises busy
    clear_all();
    dead = 1'b1;
    load(3, 8'hA5, 1'b0);
    load(3, 8'h5A, 1'b1);
    predict();
    tick();
    n = 0;
    while (!bus.o_tx_start && n < 20) begin
      tick();
      n++;
    end
    chk("t5_first_start", 32'(bus.o_tx_start), 1);
    repeat (7) tick();
    chk("t5_to_early", 32'(bus.o_timeout), 0);
    tick();
    chk("t5_to", 32'(bus.o_timeout), 1);
    wait_idle("t5_done", 200);
    chk("t5_starts3", 32'(start_cnt[3]), 2);
    chk("t5_to_sticky", 32'(bus.o_timeout), 1);
    do_reset();
    chk("t5_to_cleared", 32'(bus.o_timeout), 0);
    dead = 1'b0;

    // reset mid-byte: move ptr off zero, then reset while requester 2 is in flight
    busy_len = 40;
    load(0, 8'h11, 1'b1);
    predict();
    tick();
    rst = 1'b0;
    wait_idle("t6_pre_done", 500);
    chk("t6_ptr_pre", 32'(dut.ptr), 1);
    load(2, 8'h22, 1'b0);
    load(2, 8'h23, 1'b1);
    predict();
    tick();
    n = 0;
    while (!bus.i_tx_busy && n < 20) begin
      tick();
      n++;
    end
    chk("t6_busy_seen", 32'(bus.i_tx_busy), 1);
    repeat (3) tick();
    chk("t6_owner_mid", 32'(bus.o_grant), 32'b0100);
    do_reset();
    chk("t6_grant", 32'(bus.o_grant), 0);
    chk("t6_active", 32'(bus.o_active), 0);
    chk("t6_start", 32'(bus.o_tx_start), 0);
    chk("t6_ptr", 32'(dut.ptr), 0);
    load(0, 8'h31, 1'b1);
    load(1, 8'h41, 1'b1);
    predict();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_regrant", 32'(bus.o_grant), 32'b0001);
    wait_idle("t6_done", 500);
    chk("t6_second", 32'(got_own.size() > 1 ? got_own[1] : -1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single `uart_tx` transmitter among `N_REQ` byte-stream requesters. It sits between the message generators (status reporters, debug dumps, banner senders) and the `uart_tx` instance. It grants the transmitter for a whole packet, delimited by a `last` flag, so that messages from different sources never interleave on the serial line. It also sequences the `tx_start`/`tx_busy` handshake with `uart_tx` and detects a transmitter that never starts.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 8: cycles to wait for `i_tx_busy` to rise after a start pulse, 2..255.

- `i_Clk`  in  1  system clock (25 MHz on Go Board).
- `rst`  in  1  reset; synchronous, active-high; clock `i_Clk`.
- `i_req`  in  N_REQ  per-requester "byte available"; level, held until acked.
- `i_data`  in  8*N_REQ  requester r's byte on bits [8r+7:8r].
- `i_last`  in  N_REQ  byte currently offered by requester r ends its packet.
- `o_ack`  out  N_REQ  one-cycle pulse: requester's current byte consumed; present next byte or drop req.
- `o_grant`  out  N_REQ  one-hot current packet owner; all zero when idle.
- `o_tx_data`  out  8  to `uart_tx.tx_data`.
- `o_tx_start`  out  1  to `uart_tx.tx_start`; one-cycle pulse.
- `i_tx_busy`  in  1  from `uart_tx.tx_busy`.
- `o_active`  out  1  high whenever state != IDLE.
- `o_timeout`  out  1  sticky: a start pulse was never followed by `i_tx_busy`; cleared only by `rst`.

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE. All outputs and state are registered.
- IDLE: if `i_req` is nonzero, grant the first set bit searching upward from `ptr` (wrapping at N_REQ-1 → 0), then go to LOAD. `ptr` resets to 0.
- LOAD, when `i_req[owner]` is high:
  - latch `i_data[owner]` into `o_tx_data` and `i_last[owner]` into `last_q`;
  - pulse `o_ack[owner]`;
  - go to START.
- LOAD, when `i_req[owner]` is low: treat as packet abort. Clear `o_grant`, set `ptr` = owner+1 (mod N_REQ), go to IDLE.
- START: wait while `i_tx_busy` is high. Once it is low, pulse `o_tx_start` and go to WAIT_BUSY.
- WAIT_BUSY:
  - `i_tx_busy` high: go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches START_TIMEOUT, set `o_timeout` and proceed as if the byte completed (WAIT_DONE exit logic).
  - The counter clears on entry.
- WAIT_DONE: when `i_tx_busy` is low:
  - `last_q` = 1: clear `o_grant`, set `ptr` = owner+1 (mod N_REQ), go to IDLE.
  - Otherwise go to LOAD (same owner).
- Non-owner requests are ignored mid-packet. Grant changes only in IDLE.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` wins. No requester is starved, because `ptr` advances past each completed or aborted owner.
- `rst` mid-operation: return to IDLE immediately. `o_tx_start` may be truncated. No ack is issued for any in-flight byte.
- Undefined state encodings recover to IDLE.

## Timing
- Reset values:
  - `o_grant` = 0, `o_ack` = 0, `o_tx_data` = 8'h00;
  - `o_tx_start` = 0, `o_active` = 0, `o_timeout` = 0;
  - `ptr` = 0, state = IDLE.
- First byte, with `i_req` high at edge k while IDLE:
  - `o_grant` valid after k+1;
  - `o_ack` pulse and `o_tx_data` valid after k+2;
  - `o_tx_start` high for the one cycle after k+3, given `i_tx_busy` = 0.
- Back-to-back bytes in a packet: `i_tx_busy` sampled low at edge m gives `o_ack` after m+2 and `o_tx_start` after m+3.
- End of packet: `i_tx_busy` low at edge m gives `o_grant` = 0 after m+1. The earliest next grant is after m+2.
- Requesters update `i_data`/`i_last` in the cycle following `o_ack`. Data is sampled only in LOAD.
- `uart_tx` must raise `i_tx_busy` within START_TIMEOUT cycles of the `o_tx_start` pulse.

## Test plan
- Single packet: requester 2 sends "Hi\r\n" with `i_last` on 8'h0A, and `i_tx_busy` is modelled for 10 bit-times at 217 clocks/bit.
  - Required: four start pulses carrying 8'h48, 8'h69, 8'h0D, 8'h0A, in that order.
  - Required: `o_grant` = 4'b0100 throughout, then 0.
- Contention: requesters 0 and 3 both request from reset.
  - Required: packet 0 completes fully before any byte of requester 3, then requester 3's packet follows.
  - Required: `ptr` = 1 after the first packet, `ptr` = 0 after the second.
- Fairness: all four requesters hold `i_req` with 1-byte packets.
  - Required: grant order 0, 1, 2, 3, 0, 1, …
  - Required: no requester receives two grants within any 4 consecutive grants.
- Abort: requester 1 drops `i_req` after its second ack, with no `i_last`.
  - Required: exactly 2 start pulses, then `o_grant` returns to 0 and requester 2 is granted next.
- Timeout: `i_tx_busy` is held at 0 with START_TIMEOUT = 8.
  - Required: `o_timeout` rises 8 cycles after the start pulse.
  - Required: the next byte's start pulse still occurs, and `o_timeout` stays 1 until `rst`.
- Reset mid-byte: assert `rst` during WAIT_DONE.
  - Required: one cycle later `o_grant` = 0, `o_active` = 0, `o_tx_start` = 0, and state = IDLE.
  - Required: after release, a fresh request is granted from `ptr` = 0.
